inst_mem_loader: RTL and testbench

Boot loader that fills instruction memory before the core runs.
- Receives a byte stream over a valid/ready handshake.
- The stream is a 16-bit word count, then the instruction words, most significant byte first. This is the same big-endian word order as the hex instruction image.
- Writes each word into the instruction memory write port.
- Holds the core (IF/ID and the rest of the pipeline) until loading completes.

---
 rtl/inst_mem_loader_pkg.sv | 23 ++
 rtl/inst_mem_loader_word_assembler.sv | 42 ++++
 rtl/inst_mem_loader.sv | 136 +++++++++++++
 tb/tb_inst_mem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared loader state encodings and instruction memory constants
package inst_mem_loader_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INST_MEM_SIZE     = 256;
    localparam int LEN_WIDTH         = 16;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_HI = 3'd1,
        LDR_LEN_LO = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_WRITE  = 3'd4,
        LDR_DONE   = 3'd5,
        LDR_ERROR  = 3'd6
    } ldr_state_e;

    // States in which the loader offers rx_ready and the idle timer runs.
    function automatic logic ldr_rx_state(input ldr_state_e s);
        return (s == LDR_LEN_HI) || (s == LDR_LEN_LO) || (s == LDR_DATA);
    endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// rtl/inst_mem_loader_word_assembler.sv - big-endian byte-to-word shift register with byte counter
module word_assembler
    import inst_mem_loader_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         shift_en_i,
    input  logic [7:0]                   byte_i,
    output logic [INSTRUCTION_WIDTH-1:0] word_o,
    output logic                         word_full_o
);

    logic [INSTRUCTION_WIDTH-1:0] word_q, word_d;
    logic [1:0]                   cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (shift_en_i) begin
            word_d = {word_q[INSTRUCTION_WIDTH-9:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // High while the byte being shifted in completes the word.
    assign word_full_o = shift_en_i && !clear_i && (cnt_q == 2'd3);
    assign word_o      = word_q;

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - boot loader streaming length-prefixed words into instruction memory
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_DEPTH      = INST_MEM_SIZE,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [7:0]                   rx_data_i,
    input  logic                         rx_valid_i,
    output logic                         rx_ready_o,
    output logic                         mem_we_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [INSTRUCTION_WIDTH-1:0] mem_data_o,
    output logic                         core_hold_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [ADDR_WIDTH:0]          words_loaded_o
);

    localparam int                     IDLE_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]      IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_WIDTH-1:0]   LEN_MAX    = LEN_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]    WORDS_MAX  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    ldr_state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d;
    logic [ADDR_WIDTH:0]          words_q, words_d;
    logic [IDLE_W-1:0]            idle_q, idle_d;
    logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
    logic [INSTRUCTION_WIDTH-1:0] mem_data_q, mem_data_d;

    logic                         rx_accept;
    logic                         asm_clear;
    logic                         asm_full;
    logic [INSTRUCTION_WIDTH-1:0] asm_word;
    logic [LEN_WIDTH-1:0]         n_len;
    logic [ADDR_WIDTH:0]          words_inc;

    assign rx_ready_o = ldr_rx_state(state_q);
    assign rx_accept  = rx_ready_o && rx_valid_i;

    word_assembler u_word_assembler (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (asm_clear),
        .shift_en_i  (rx_accept && (state_q == LDR_DATA)),
        .byte_i      (rx_data_i),
        .word_o      (asm_word),
        .word_full_o (asm_full)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        words_d    = words_q;
        idle_d     = idle_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        asm_clear  = 1'b0;
        n_len      = {len_q[LEN_WIDTH-1:8], rx_data_i};
        words_inc  = words_q + 1'b1;

        unique case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                if (start_i) begin
                    state_d   = LDR_LEN_HI;
                    words_d   = '0;
                    idle_d    = '0;
                    asm_clear = 1'b1;
                end
            end
            LDR_LEN_HI: begin
                if (rx_accept) begin
                    len_d[LEN_WIDTH-1:8] = rx_data_i;
                    state_d              = LDR_LEN_LO;
                end
            end
            LDR_LEN_LO: begin
                if (rx_accept) begin
                    len_d = n_len;
                    if (n_len == '0)          state_d = LDR_DONE;
                    else if (n_len > LEN_MAX) state_d = LDR_ERROR;
                    else                      state_d = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (rx_accept && asm_full) state_d = LDR_WRITE;
            end
            LDR_WRITE: begin
                // Latch the port so it keeps showing the last write once loading stops.
                mem_addr_d = words_q[ADDR_WIDTH-1:0];
                mem_data_d = asm_word;
                if (words_q != WORDS_MAX) words_d = words_inc;
                state_d = (LEN_WIDTH'(words_inc) == len_q) ? LDR_DONE : LDR_DATA;
            end
            default: state_d = LDR_IDLE;
        endcase

        if (ldr_rx_state(state_q)) begin
            if (rx_accept)                idle_d = '0;
            else if (idle_q == IDLE_LIMIT) state_d = LDR_ERROR;
            else                          idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LDR_IDLE;
            len_q      <= '0;
            words_q    <= '0;
            idle_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_q    <= words_d;
            idle_q     <= idle_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_we_o       = (state_q == LDR_WRITE);
    assign mem_addr_o     = mem_we_o ? words_q[ADDR_WIDTH-1:0] : mem_addr_q;
    assign mem_data_o     = mem_we_o ? asm_word : mem_data_q;
    assign done_o         = (state_q == LDR_DONE);
    assign error_o        = (state_q == LDR_ERROR);
    assign core_hold_o    = (state_q != LDR_DONE);
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - self-checking bench for inst_mem_loader
module tb_inst_mem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int TO    = 1024;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          rx_valid_i = 1'b0;
    logic          rx_ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic          core_hold_o;
    logic          done_o;
    logic          error_o;
    logic [AW:0]   words_loaded_o;

    inst_mem_loader #(
        .ADDR_WIDTH     (AW),
        .MEM_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .core_hold_o    (core_hold_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stream_q[$];
    logic [39:0] got_q[$];
    logic [39:0] exp_q[$];
    bit          exp_done, exp_error;
    int          exp_words, exp_to;

    typedef struct {
        logic [111:0] stream;
        int           nbytes;
        int           mode;
        bit           exp_done;
        bit           exp_error;
        int           exp_words;
        logic [31:0]  exp_first;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && mem_we_o) begin
            got_q.push_back({mem_addr_o, mem_data_o});
            chk("rx_ready_in_write", {63'd0, rx_ready_o}, 64'd0);
        end
    end

    // Reference: parse the stream as length header plus big-endian words.
    task automatic model();
        int sz, n, nfull, wl;
        logic [7:0] a;
        sz = stream_q.size();
        exp_q.delete();
        exp_done = 0; exp_error = 0; exp_words = 0; exp_to = 0;
        n = {16'd0, stream_q[0], stream_q[1]};
        if (n == 0) begin
            exp_done = 1;
        end else if (n > DEPTH) begin
            exp_error = 1;
        end else begin
            nfull = (sz - 2) / 4;
            wl = (nfull < n) ? nfull : n;
            for (int i = 0; i < wl; i++) begin
                a = 8'(i);
                exp_q.push_back({a, stream_q[2+4*i], stream_q[3+4*i], stream_q[4+4*i], stream_q[5+4*i]});
            end
            exp_words = wl;
            if (nfull >= n) exp_done = 1;
            else begin
                exp_error = 1;
                exp_to = TO + ((sz > 2 && (sz - 2) % 4 == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, {63'd0, rx_ready_o}, 64'd0);
        chk({tag, "_mem_we"},   {63'd0, mem_we_o}, 64'd0);
        chk({tag, "_mem_addr"}, {56'd0, mem_addr_o}, 64'd0);
        chk({tag, "_mem_data"}, {32'd0, mem_data_o}, 64'd0);
        chk({tag, "_done"},     {63'd0, done_o}, 64'd0);
        chk({tag, "_error"},    {63'd0, error_o}, 64'd0);
        chk({tag, "_words"},    {55'd0, words_loaded_o}, 64'd0);
        chk({tag, "_core_hold"},{63'd0, core_hold_o}, 64'd1);
    endtask

    task automatic start_load();
        start_i    = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = stream_q[0];
        got_q.delete();
        #1;
        chk("ready_with_start", {63'd0, rx_ready_o}, 64'd0);
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        chk("start_done_clr",  {63'd0, done_o}, 64'd0);
        chk("start_error_clr", {63'd0, error_o}, 64'd0);
        chk("start_hold",      {63'd0, core_hold_o}, 64'd1);
        chk("start_words_clr", {55'd0, words_loaded_o}, 64'd0);
    endtask

    // mode 0: valid always; 1: toggling; 2: random; 3: always valid plus a stray start mid-load
    task automatic feed(input int mode, input int limit);
        int idx, cyc;
        bit took, brk;
        idx = 0; cyc = 0;
        while (idx < limit && cyc < 2000) begin
            rx_data_i = stream_q[idx];
            case (mode)
                1:       rx_valid_i = (cyc % 2 == 0);
                2:       rx_valid_i = 1'($urandom_range(0, 1));
                default: rx_valid_i = 1'b1;
            endcase
            start_i = (mode == 3 && cyc == 6);
            @(negedge clk_i);
            took = rx_valid_i && rx_ready_o;
            brk  = done_o || error_o;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (took) idx++;
            cyc++;
            if (brk) break;
        end
        rx_valid_i = 1'b0;
        chk("feed_budget", {63'd0, (cyc < 2000)}, 64'd1);
    endtask

    task automatic run_vec(input int mode, input string tag);
        int n;
        model();
        start_load();
        feed(mode, stream_q.size());
        if (exp_done && exp_q.size() > 0) begin
            chk({tag, "_we_after_last"}, {63'd0, mem_we_o}, 64'd1);
            chk({tag, "_done_early"},    {63'd0, done_o}, 64'd0);
        end
        n = 0;
        while (!(done_o || error_o) && n < 1200) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, "_finish_bound"}, {63'd0, (done_o || error_o)}, 64'd1);
        if (exp_done && exp_q.size() > 0) chk({tag, "_done_latency"}, 64'(n), 64'd1);
        if (exp_error) chk({tag, "_error_cycles"}, 64'(n), 64'(exp_to));
        @(negedge clk_i);
        chk({tag, "_done"},      {63'd0, done_o}, {63'd0, exp_done});
        chk({tag, "_error"},     {63'd0, error_o}, {63'd0, exp_error});
        chk({tag, "_core_hold"}, {63'd0, core_hold_o}, {63'd0, !exp_done});
        chk({tag, "_mem_we"},    {63'd0, mem_we_o}, 64'd0);
        chk({tag, "_words"},     {55'd0, words_loaded_o}, 64'(exp_words));
        chk({tag, "_nwrites"},   64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_write"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        @(posedge clk_i); #1;
    endtask

    task automatic load_stream(input logic [111:0] s, input int nb);
        stream_q.delete();
        for (int i = 0; i < nb; i++) stream_q.push_back(s[8*(nb-1-i) +: 8]);
    endtask

    initial begin
        int n, drop;
        vecs[0] = '{112'h0003_12345678_9ABCDEF0_00000001, 14, 0, 1, 0, 3, 32'h12345678};
        vecs[1] = '{112'h0003_12345678_9ABCDEF0_00000001, 14, 1, 1, 0, 3, 32'h12345678};
        vecs[2] = '{112'h0101,                             2,  0, 0, 1, 0, 32'h0};
        vecs[3] = '{112'h0002_11223344_55,                 7,  0, 0, 1, 1, 32'h11223344};
        vecs[4] = '{112'h0000,                             2,  0, 1, 0, 0, 32'h0};
        vecs[5] = '{112'h0001_AABBCCDD,                    6,  0, 1, 0, 1, 32'hAABBCCDD};
        vecs[6] = '{112'h0002_CAFEF00D_01020304,           10, 3, 1, 0, 2, 32'hCAFEF00D};

        #1;
        check_reset_vals("reset");
        #12 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int v = 0; v < 7; v++) begin
            load_stream(vecs[v].stream, vecs[v].nbytes);
            run_vec(vecs[v].mode, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tbl_done", v), {63'd0, done_o}, {63'd0, vecs[v].exp_done});
            chk($sformatf("vec%0d_tbl_error", v), {63'd0, error_o}, {63'd0, vecs[v].exp_error});
            chk($sformatf("vec%0d_tbl_words", v), {55'd0, words_loaded_o}, 64'(vecs[v].exp_words));
            if (vecs[v].exp_words > 0 && got_q.size() > 0)
                chk($sformatf("vec%0d_tbl_first", v), {32'd0, got_q[0][31:0]}, {32'd0, vecs[v].exp_first});
        end

        // Asynchronous reset in the middle of a word, then a clean reload.
        load_stream(vecs[0].stream, vecs[0].nbytes);
        start_load();
        feed(0, 4);
        #2 rst_ni = 1'b0;
        #1 check_reset_vals("async_reset");
        @(posedge clk_i); #3 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_vec(0, "after_reset");

        for (int r = 0; r < 24; r++) begin
            stream_q.delete();
            if (r % 8 == 5) n = 257 + $urandom_range(0, 100);
            else            n = $urandom_range(0, 6);
            stream_q.push_back(8'(n >> 8));
            stream_q.push_back(8'(n));
            if (n <= DEPTH)
                for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom_range(0, 255)));
            if ((r % 10 == 3) && n > 0 && n <= DEPTH) begin
                drop = $urandom_range(1, 4);
                for (int i = 0; i < drop; i++) void'(stream_q.pop_back());
            end
            run_vec($urandom_range(0, 2), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
